// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

    localparam int unsigned LSU_LATENCY_DEFAULT = 2;
    localparam int unsigned XLEN                = 32;

    // RV32I load/store funct3 encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_e;

    // Request captured at accept and held for the whole access
    typedef struct packed {
        logic            is_store;
        logic [2:0]      funct3;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } lsu_req_t;

    // Access width; unknown encodings fall back to a full word
    function automatic lsu_size_e access_size(input logic is_store, input logic [2:0] f3);
        lsu_size_e sz;
        sz = SZ_W;
        if (is_store) begin
            if (f3 == F3_B)      sz = SZ_B;
            else if (f3 == F3_H) sz = SZ_H;
        end else begin
            if (f3 == F3_B || f3 == F3_BU)      sz = SZ_B;
            else if (f3 == F3_H || f3 == F3_HU) sz = SZ_H;
        end
        return sz;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: load extraction/extension and store merge into an old word.
// Half and word lanes ignore the low offset bits, so misaligned offsets align down.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  lsu_size_e        size_i,
    input  logic             unsigned_i,
    input  logic [1:0]       off_i,
    input  logic [XLEN-1:0]  word_i,
    input  logic [XLEN-1:0]  wdata_i,
    output logic [XLEN-1:0]  load_data_c_o,
    output logic [XLEN-1:0]  store_word_c_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane and extend it to a full word
    always_comb begin
        byte_sel      = word_i[{off_i, 3'b000} +: 8];
        half_sel      = word_i[{off_i[1], 4'b0000} +: 16];
        load_data_c_o = word_i;
        case (size_i)
            SZ_B:    load_data_c_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
            SZ_H:    load_data_c_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
            default: load_data_c_o = word_i;
        endcase
    end

    // Overlay store data on the addressed lane, keeping the other bytes
    always_comb begin
        store_word_c_o = word_i;
        case (size_i)
            SZ_B:    store_word_c_o[{off_i, 3'b000} +: 8]     = wdata_i[7:0];
            SZ_H:    store_word_c_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            default: store_word_c_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle data-memory stage: byte/half/word loads and stores with fixed latency.
// Optional macro LSU_MISALIGN_TRAP_EN reports misaligned accesses instead of aligning them down.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned DEPTH   = 128,
    parameter int unsigned LATENCY = LSU_LATENCY_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             memread,
    input  logic             memwrite,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  address,
    input  logic [XLEN-1:0]  writedata,
    output logic             rsp_valid,
    output logic [XLEN-1:0]  readdata,
    output logic             stall,
    output logic             misalign
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = 4;

    lsu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    lsu_req_t          req_q, req_d;
    logic [XLEN-1:0]   readdata_q, readdata_d;
    logic              misalign_q, misalign_d;

    logic              accept_c;
    logic              commit_c;
    logic              mis_c;
    logic              we_c;
    lsu_size_e         size_c;
    logic [IDX_W-1:0]  idx_c;
    logic [XLEN-1:0]   word_rd_c;
    logic [XLEN-1:0]   load_data_c;
    logic [XLEN-1:0]   store_word_c;
    logic [XLEN-1:0]   mem_rd [DEPTH];

    assign size_c    = access_size(req_q.is_store, req_q.funct3);
    assign idx_c     = IDX_W'(req_q.addr[31:2] % 30'(DEPTH));
    assign word_rd_c = mem_rd[idx_c];
    assign we_c      = commit_c && req_q.is_store && !mis_c && rst;

`ifdef LSU_MISALIGN_TRAP_EN
    // Halves need an even address, words a word-aligned one
    always_comb begin
        mis_c = 1'b0;
        case (size_c)
            SZ_H:    mis_c = req_q.addr[0];
            SZ_W:    mis_c = |req_q.addr[1:0];
            default: mis_c = 1'b0;
        endcase
    end
`else
    assign mis_c = 1'b0;
`endif

    lsu_lane_align u_lane_align (
        .size_i         (size_c),
        .unsigned_i     (req_q.funct3[2]),
        .off_i          (req_q.addr[1:0]),
        .word_i         (word_rd_c),
        .wdata_i        (req_q.wdata),
        .load_data_c_o  (load_data_c),
        .store_word_c_o (store_word_c)
    );

    // Data array: word i powers up holding i and survives reset
    for (genvar g = 0; g < int'(DEPTH); g++) begin : g_word
        logic [XLEN-1:0] word_q = XLEN'(g);
        // Commit the merged store word when this entry is addressed
        always_ff @(posedge clk) begin
            if (we_c && (idx_c == IDX_W'(g))) begin
                word_q <= store_word_c;
            end
        end
        assign mem_rd[g] = word_q;
    end

    // Next-state and access control
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        readdata_d = readdata_q;
        misalign_d = misalign_q;
        accept_c   = 1'b0;
        commit_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && (memread || memwrite)) begin
                    accept_c = 1'b1;
                    req_d    = '{is_store: memwrite, funct3: funct3,
                                 addr: address, wdata: writedata};
                    cnt_d    = CNT_W'(LATENCY - 1);
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    commit_c   = 1'b1;
                    misalign_d = mis_c;
                    if (!req_q.is_store && !mis_c) begin
                        readdata_d = load_data_c;
                    end
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            req_q      <= '0;
            readdata_q <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            readdata_q <= readdata_d;
            misalign_q <= misalign_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign stall     = accept_c || (state_q == BUSY);
    assign readdata  = readdata_q;
    assign misalign  = misalign_q;

endmodule
